// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame scheduler and its framebuffer write buffer.
package frame_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN,
        S_FLUSH
    } sched_state_t;

    localparam int ERR_BADX   = 0;
    localparam int ERR_OVF    = 1;
    localparam int ERR_TMO    = 2;
    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/frame_scheduler_if.sv
// Valid/ready framebuffer write bus; the scheduler is master, the framebuffer is slave.
interface frame_scheduler_if #(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DEPTH_WIDTH = 10
);
    logic                   fb_we;
    logic [ADDR_WIDTH-1:0]  fb_addr;
    logic [DEPTH_WIDTH-1:0] fb_data;
    logic                   fb_ready;

    modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/fb_write_fifo.sv
// Small registered FIFO of {addr, data} framebuffer writes; the head entry is presented directly.
module fb_write_fifo
    import frame_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DEPTH_WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [ADDR_WIDTH-1:0]  push_addr_i,
    input  logic [DEPTH_WIDTH-1:0] push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [ADDR_WIDTH-1:0]  head_addr_o,
    output logic [DEPTH_WIDTH-1:0] head_data_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0]  addr_q [FIFO_DEPTH];
    logic [DEPTH_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]         count_q;
    logic                   push_ok, pop_ok;

    assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A full buffer still takes a new entry when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign valid_o     = !empty_o;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/frame_scheduler.sv
// Walks the line renderer through a frame, linearises its pixel writes into framebuffer
// writes and handles abort, overflow, bad-x and per-line stall detection.
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned ADDR_WIDTH    = 19,
    parameter int unsigned DEPTH_WIDTH   = 10,
    parameter int unsigned LINE_TIMEOUT  = 1048576
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   frame_req_i,
    input  logic                   frame_abort_i,
    output logic                   frame_busy_o,
    output logic                   frame_done_o,
    output logic                   frame_aborted_o,
    output logic [8:0]             line_idx_o,
    output logic                   eng_start_o,
    output logic                   eng_rst_o,
    input  logic                   eng_done_i,
    input  logic                   eng_we_i,
    input  logic [9:0]             eng_x_i,
    input  logic [DEPTH_WIDTH-1:0] eng_depth_i,
    frame_scheduler_if.master      fb,
    output logic [2:0]             err_o
);
    localparam int unsigned         PIX_W       = $clog2(SCREEN_WIDTH + 1);
    localparam int unsigned         TMO_W       = $clog2(LINE_TIMEOUT + 1);
    localparam logic [8:0]          LAST_LINE   = 9'(SCREEN_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    sched_state_t          state_q, state_d;
    logic [8:0]            line_q, line_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [2:0]            err_q, err_d;
    logic                  abort_q, abort_d;
    logic                  flush_q, flush_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  eng_rst_q, eng_rst_d;

    logic                  x_ok, wr_seen, pop, abort_now;
    logic                  fifo_valid, fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0] push_addr;

    assign x_ok      = (32'(eng_x_i) < SCREEN_WIDTH);
    assign wr_seen   = (state_q == S_RUN) && eng_we_i && x_ok;
    assign push_addr = base_q + ADDR_WIDTH'(eng_x_i);
    assign pop       = fifo_valid && fb.fb_ready;
    assign abort_now = abort_q || (frame_abort_i && busy_q);

    fb_write_fifo #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WIDTH (DEPTH_WIDTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (wr_seen),
        .push_addr_i (push_addr),
        .push_data_i (eng_depth_i),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_addr_o (fb.fb_addr),
        .head_data_o (fb.fb_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        base_d    = base_q;
        pix_d     = pix_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        abort_d   = abort_q;
        flush_d   = flush_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (frame_abort_i && busy_q) abort_d = 1'b1;
        // Writes lost to a full buffer still count toward line completion.
        if (wr_seen) pix_d = pix_q + PIX_W'(1);
        if ((state_q == S_RUN) && eng_we_i && !x_ok) err_d[ERR_BADX] = 1'b1;
        if (wr_seen && fifo_full && !pop) err_d[ERR_OVF] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (frame_req_i) begin
                    err_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                    abort_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                pix_d   = '0;
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if ((pix_q == PIX_W'(SCREEN_WIDTH)) && eng_done_i) begin
                    state_d = S_DRAIN;
                end else if (tmo_q == TMO_W'(LINE_TIMEOUT - 1)) begin
                    err_d[ERR_TMO] = 1'b1;
                    abort_d        = 1'b1;
                    state_d        = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    if (line_q == LAST_LINE) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (abort_now) begin
                        flush_d = 1'b0;
                        state_d = S_FLUSH;
                    end else begin
                        line_d  = line_q + 9'd1;
                        base_d  = base_q + LINE_STRIDE;
                        state_d = S_START;
                    end
                end
            end
            S_FLUSH: begin
                if (!flush_q) begin
                    flush_d = 1'b1;
                end else begin
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The renderer is held in reset for the whole flush so its y counter restarts.
        eng_rst_d = (state_d == S_FLUSH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            base_q    <= '0;
            pix_q     <= '0;
            tmo_q     <= '0;
            err_q     <= '0;
            abort_q   <= 1'b0;
            flush_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            eng_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            base_q    <= base_d;
            pix_q     <= pix_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            flush_q   <= flush_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            eng_rst_q <= eng_rst_d;
        end
    end

    assign frame_busy_o    = busy_q;
    assign frame_done_o    = done_q;
    assign frame_aborted_o = aborted_q;
    assign line_idx_o      = line_q;
    assign eng_start_o     = (state_q == S_START);
    assign eng_rst_o       = eng_rst_q;
    assign fb.fb_we        = fifo_valid;
    assign err_o           = err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on an 8x4 screen with a 50-cycle line timeout.
module tb_frame_scheduler;
    localparam int unsigned W   = 8;
    localparam int unsigned H   = 4;
    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 10;
    localparam int unsigned TMO = 50;

    logic          clk = 1'b0;
    logic          rstN;
    logic          frameReq, frameAbort, frameBusy, frameDone, frameAborted;
    logic          engStart, engRst, engDone, engWe;
    logic [8:0]    lineIdx;
    logic [9:0]    engX;
    logic [DW-1:0] engDepth;
    logic [2:0]    err;

    int   assertCount = 0;
    int   failCount   = 0;
    int   startCount, doneCount, abortedCount, rstCycles;
    logic readyMode  = 1'b0;
    logic readyLevel = 1'b1;
    int   readyPhase = 0;

    logic [AW-1:0] expAddr[$];
    logic [DW-1:0] expData[$];
    logic [AW-1:0] gotAddr[$];

    frame_scheduler_if #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) fbBus();

    frame_scheduler #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW),
        .DEPTH_WIDTH(DW), .LINE_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .frame_req_i(frameReq), .frame_abort_i(frameAbort),
        .frame_busy_o(frameBusy), .frame_done_o(frameDone), .frame_aborted_o(frameAborted),
        .line_idx_o(lineIdx), .eng_start_o(engStart), .eng_rst_o(engRst),
        .eng_done_i(engDone), .eng_we_i(engWe), .eng_x_i(engX), .eng_depth_i(engDepth),
        .fb(fbBus), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] depthOf(input int line, input int x);
        return DW'(line * 37 + x * 5 + 3);
    endfunction

    // One renderer write; writes expected to reach the framebuffer are queued in order.
    task automatic applyStimulus(input int line, input int x, input bit lands);
        engWe    = 1'b1;
        engX     = 10'(x);
        engDepth = depthOf(line, x);
        if (lands) begin
            expAddr.push_back(AW'(line * int'(W) + x));
            expData.push_back(depthOf(line, x));
        end
        tick();
        engWe = 1'b0;
    endtask

    task automatic finishLine();
        engDone = 1'b1;
        tick();
        engDone = 1'b0;
    endtask

    task automatic renderLine(input int line);
        for (int x = 0; x < int'(W); x++) applyStimulus(line, x, 1'b1);
        finishLine();
    endtask

    task automatic waitStart(input string tag);
        int n = 0;
        while (!engStart && n < 200) begin
            tick();
            n++;
        end
        if (!engStart) checkOutput(tag, 32'(engStart), 32'(1));
        tick();
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (frameBusy && n < 400) begin
            tick();
            n++;
        end
        if (frameBusy) checkOutput(tag, 32'(frameBusy), 32'(0));
        tick();
    endtask

    task automatic requestFrame();
        frameReq = 1'b1;
        tick();
        frameReq = 1'b0;
    endtask

    task automatic resetCounts();
        startCount = 0; doneCount = 0; abortedCount = 0; rstCycles = 0;
    endtask

    task automatic checkStream(input string tag);
        checkOutput(tag, 32'(gotAddr.size()), 32'(expAddr.size()));
        gotAddr.delete();
        expAddr.delete();
        expData.delete();
    endtask

    initial begin
        fbBus.fb_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (readyMode) begin
                readyPhase     = (readyPhase + 1) % 3;
                fbBus.fb_ready = (readyPhase == 0);
            end else begin
                fbBus.fb_ready = readyLevel;
            end
        end
    end

    // The presented head must always be the oldest write the bench expects to land.
    always @(negedge clk) begin
        if (rstN) begin
            if (fbBus.fb_we) begin
                if (gotAddr.size() < expAddr.size()) begin
                    checkOutput("fb head addr", 32'(fbBus.fb_addr), 32'(expAddr[gotAddr.size()]));
                    checkOutput("fb head data", 32'(fbBus.fb_data), 32'(expData[gotAddr.size()]));
                end else begin
                    checkOutput("spurious fb_we", 32'(fbBus.fb_we), 32'(0));
                end
                if (fbBus.fb_ready) gotAddr.push_back(fbBus.fb_addr);
            end
            if (engStart)     startCount++;
            if (frameDone)    doneCount++;
            if (frameAborted) abortedCount++;
            if (engRst)       rstCycles++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; frameReq = 1'b0; frameAbort = 1'b0;
        engDone = 1'b0; engWe = 1'b0; engX = '0; engDepth = '0;
        resetCounts();

        #12;
        checkOutput("reset eng_rst", 32'(engRst), 32'(1));
        checkOutput("reset busy", 32'(frameBusy), 32'(0));
        checkOutput("reset fb_we", 32'(fbBus.fb_we), 32'(0));
        checkOutput("reset fb_addr", 32'(fbBus.fb_addr), 32'(0));
        checkOutput("reset err", 32'(err), 32'(0));
        checkOutput("reset eng_start", 32'(engStart), 32'(0));
        tick();
        rstN = 1'b1;
        #1;
        checkOutput("eng_rst before first edge", 32'(engRst), 32'(1));
        tick();
        checkOutput("eng_rst after first edge", 32'(engRst), 32'(0));

        $display("[TB] nominal frame");
        resetCounts();
        requestFrame();
        checkOutput("busy after req", 32'(frameBusy), 32'(1));
        for (int l = 0; l < int'(H); l++) begin
            waitStart("nominal start");
            renderLine(l);
        end
        waitIdle("nominal idle");
        checkOutput("nominal starts", 32'(startCount), 32'(4));
        checkOutput("nominal done", 32'(doneCount), 32'(1));
        checkOutput("nominal aborted", 32'(abortedCount), 32'(0));
        checkOutput("nominal err", 32'(err), 32'(0));
        checkOutput("nominal line_idx", 32'(lineIdx), 32'(3));
        checkStream("nominal write count");

        $display("[TB] backpressure");
        resetCounts();
        readyMode = 1'b1;
        requestFrame();
        for (int l = 0; l < int'(H); l++) begin
            waitStart("bp start");
            for (int x = 0; x < int'(W); x += 2) begin
                applyStimulus(l, x, 1'b1);
                applyStimulus(l, x + 1, 1'b1);
                repeat (4) tick();
            end
            finishLine();
        end
        waitIdle("bp idle");
        readyMode = 1'b0;
        checkOutput("bp done", 32'(doneCount), 32'(1));
        checkOutput("bp err", 32'(err), 32'(0));
        checkStream("bp write count");

        $display("[TB] overflow");
        resetCounts();
        readyLevel = 1'b0;
        tick();
        requestFrame();
        waitStart("ovf start");
        for (int x = 0; x < 6; x++) applyStimulus(0, x, x < 4);
        checkOutput("ovf err", 32'(err), 32'(3'b010));
        checkOutput("ovf head addr", 32'(fbBus.fb_addr), 32'(0));
        frameAbort = 1'b1;
        tick();
        frameAbort = 1'b0;
        readyLevel = 1'b1;
        repeat (6) tick();
        applyStimulus(0, 6, 1'b1);
        applyStimulus(0, 7, 1'b1);
        finishLine();
        waitIdle("ovf idle");
        checkOutput("ovf done", 32'(doneCount), 32'(0));
        checkOutput("ovf aborted", 32'(abortedCount), 32'(1));
        checkOutput("ovf err sticky", 32'(err), 32'(3'b010));
        checkStream("ovf write count");

        $display("[TB] bad x");
        resetCounts();
        requestFrame();
        for (int l = 0; l < int'(H); l++) begin
            waitStart("badx start");
            if (l == 2) checkOutput("badx err before", 32'(err), 32'(0));
            for (int x = 0; x < int'(W); x++) begin
                applyStimulus(l, x, 1'b1);
                if (l == 2 && x == 3) applyStimulus(l, 9, 1'b0);
                if (l == 3 && x == 5) applyStimulus(l, 8, 1'b0);
            end
            finishLine();
        end
        waitIdle("badx idle");
        checkOutput("badx err", 32'(err), 32'(3'b001));
        checkOutput("badx done", 32'(doneCount), 32'(1));
        checkStream("badx write count");

        $display("[TB] abort");
        resetCounts();
        requestFrame();
        waitStart("abort start0");
        renderLine(0);
        waitStart("abort start1");
        for (int x = 0; x < 3; x++) applyStimulus(1, x, 1'b1);
        frameAbort = 1'b1;
        tick();
        frameAbort = 1'b0;
        for (int x = 3; x < int'(W); x++) applyStimulus(1, x, 1'b1);
        finishLine();
        for (int n = 0; n < 50 && !engRst; n++) tick();
        checkOutput("abort eng_rst seen", 32'(engRst), 32'(1));
        applyStimulus(1, 5, 1'b0);
        waitIdle("abort idle");
        checkOutput("abort starts", 32'(startCount), 32'(2));
        checkOutput("abort done", 32'(doneCount), 32'(0));
        checkOutput("abort aborted", 32'(abortedCount), 32'(1));
        checkOutput("abort eng_rst cycles", 32'(rstCycles), 32'(2));
        checkOutput("abort line_idx", 32'(lineIdx), 32'(1));
        checkOutput("abort err", 32'(err), 32'(0));
        checkStream("abort write count");

        $display("[TB] timeout");
        resetCounts();
        requestFrame();
        waitStart("tmo start");
        for (int x = 0; x < int'(W); x++) applyStimulus(0, x, 1'b1);
        repeat (41) tick();
        checkOutput("tmo not yet", 32'(err), 32'(0));
        tick();
        checkOutput("tmo set", 32'(err), 32'(3'b100));
        waitIdle("tmo idle");
        checkOutput("tmo aborted", 32'(abortedCount), 32'(1));
        checkOutput("tmo done", 32'(doneCount), 32'(0));
        checkOutput("tmo eng_rst cycles", 32'(rstCycles), 32'(2));
        checkStream("tmo write count");

        resetCounts();
        frameReq   = 1'b1;
        frameAbort = 1'b1;
        tick();
        frameReq   = 1'b0;
        frameAbort = 1'b0;
        checkOutput("req+abort busy", 32'(frameBusy), 32'(1));
        checkOutput("req+abort err cleared", 32'(err), 32'(0));
        waitStart("req+abort start0");
        renderLine(0);
        waitStart("req+abort start1");
        checkOutput("req+abort line_idx", 32'(lineIdx), 32'(1));
        frameAbort = 1'b1;
        tick();
        frameAbort = 1'b0;
        renderLine(1);
        waitIdle("req+abort idle");
        checkOutput("req+abort starts", 32'(startCount), 32'(2));
        checkOutput("req+abort aborted", 32'(abortedCount), 32'(1));
        checkStream("req+abort write count");

        $display("[TB] async reset mid-frame");
        requestFrame();
        waitStart("arst start0");
        renderLine(0);
        waitStart("arst start1");
        readyLevel = 1'b0;
        applyStimulus(1, 0, 1'b1);
        applyStimulus(1, 1, 1'b1);
        checkOutput("arst fb_we before", 32'(fbBus.fb_we), 32'(1));
        checkOutput("arst line_idx before", 32'(lineIdx), 32'(1));
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst busy", 32'(frameBusy), 32'(0));
        checkOutput("arst fb_we", 32'(fbBus.fb_we), 32'(0));
        checkOutput("arst eng_rst", 32'(engRst), 32'(1));
        checkOutput("arst line_idx", 32'(lineIdx), 32'(0));
        checkOutput("arst eng_start", 32'(engStart), 32'(0));
        gotAddr.delete();
        expAddr.delete();
        expData.delete();
        tick();
        rstN       = 1'b1;
        readyLevel = 1'b1;
        tick();
        checkOutput("arst eng_rst released", 32'(engRst), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
